// File: rtl/execute_muldiv.sv
// execute_muldiv: LEGv8 execute stage. Single-cycle ALU ops plus an iterative
// shift-add multiplier and restoring divider sharing one small FSM.
// Optional feature macro: EXEC_FLAGS_EN adds the registered nzcv output.
module execute_muldiv #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_control,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             zero
`ifdef EXEC_FLAGS_EN
    ,
    output logic [3:0]       nzcv
`endif
);

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_ORR   = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_PASSB = 4'b0111;
    localparam logic [3:0] OP_NOR   = 4'b1100;
    localparam logic [3:0] OP_MUL   = 4'b1000;
    localparam logic [3:0] OP_UDIV  = 4'b1001;
    localparam logic [3:0] OP_SDIV  = 4'b1010;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc;      // MUL partial product
    logic [WIDTH-1:0] opa;      // MUL multiplicand / DIV dividend shifting into quotient
    logic [WIDTH-1:0] opb;      // MUL multiplier / DIV divisor
    logic [WIDTH-1:0] rem;      // DIV partial remainder
    logic             neg;      // SDIV quotient needs negating

    logic [WIDTH-1:0] sc_res;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             is_div, long_op;
    logic [WIDTH-1:0] mul_acc_nx;
    logic [WIDTH:0]   rem_sh, rem_diff;
    logic             div_ok;
    logic [WIDTH-1:0] quot_nx, div_res;
    logic             res_we;
    logic [WIDTH-1:0] res_nx;

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);

    // Single-cycle ALU result from the live inputs (only used on the accept edge)
    always_comb begin
        sc_res = '0;
        case (alu_control)
            OP_AND:   sc_res = a & b;
            OP_ORR:   sc_res = a | b;
            OP_ADD:   sc_res = a + b;
            OP_SUB:   sc_res = a - b;
            OP_PASSB: sc_res = b;
            OP_NOR:   sc_res = ~(a | b);
            default:  sc_res = '0;   // undefined codes and divide-by-zero
        endcase
    end

    // Operand classification and one step of the multiply / divide datapaths
    always_comb begin
        a_mag      = a[WIDTH-1] ? -a : a;
        b_mag      = b[WIDTH-1] ? -b : b;
        is_div     = (alu_control == OP_UDIV) || (alu_control == OP_SDIV);
        long_op    = (alu_control == OP_MUL) || (is_div && (b != '0));
        mul_acc_nx = acc + (opb[0] ? opa : '0);
        rem_sh     = {rem, opa[WIDTH-1]};
        rem_diff   = rem_sh - {1'b0, opb};
        div_ok     = ~rem_diff[WIDTH];
        quot_nx    = {opa[WIDTH-2:0], div_ok};
        div_res    = neg ? -quot_nx : quot_nx;
    end

    // Pick the value written into result on the edge that enters DONE
    always_comb begin
        res_we = 1'b0;
        res_nx = sc_res;
        case (state)
            ST_IDLE: res_we = in_valid && !long_op;
            ST_MUL: begin
                res_we = (cnt == CNT_LAST);
                res_nx = mul_acc_nx;
            end
            ST_DIV: begin
                res_we = (cnt == CNT_LAST);
                res_nx = div_res;
            end
            default: res_we = 1'b0;
        endcase
    end

`ifdef EXEC_FLAGS_EN
    logic [1:0] cv_nx;

    // Carry / overflow only for ADD and SUB taken on the accept edge
    always_comb begin
        cv_nx = 2'b00;
        if (state == ST_IDLE) begin
            if (alu_control == OP_ADD)
                cv_nx = {sc_res < a,
                         (a[WIDTH-1] == b[WIDTH-1]) && (sc_res[WIDTH-1] != a[WIDTH-1])};
            else if (alu_control == OP_SUB)
                cv_nx = {a >= b,
                         (a[WIDTH-1] != b[WIDTH-1]) && (sc_res[WIDTH-1] != a[WIDTH-1])};
        end
    end
`endif

    // Output registers: updated only when entering DONE, held otherwise
    always_ff @(posedge clk) begin
        if (reset) begin
            result <= '0;
            zero   <= 1'b1;
`ifdef EXEC_FLAGS_EN
            nzcv   <= 4'b0000;
`endif
        end else if (res_we) begin
            result <= res_nx;
            zero   <= (res_nx == '0);
`ifdef EXEC_FLAGS_EN
            nzcv   <= {res_nx[WIDTH-1], (res_nx == '0), cv_nx};
`endif
        end
    end

    // Control FSM and iterative multiply/divide state
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            acc   <= '0;
            opa   <= '0;
            opb   <= '0;
            rem   <= '0;
            neg   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (in_valid) begin
                    cnt <= '0;
                    acc <= '0;
                    rem <= '0;
                    if (alu_control == OP_MUL) begin
                        opa   <= a;
                        opb   <= b;
                        state <= ST_MUL;
                    end else if (long_op) begin
                        opa   <= (alu_control == OP_SDIV) ? a_mag : a;
                        opb   <= (alu_control == OP_SDIV) ? b_mag : b;
                        neg   <= (alu_control == OP_SDIV) && (a[WIDTH-1] ^ b[WIDTH-1]);
                        state <= ST_DIV;
                    end else begin
                        state <= ST_DONE;
                    end
                end
                ST_MUL: begin
                    acc <= mul_acc_nx;
                    opa <= opa << 1;
                    opb <= opb >> 1;
                    cnt <= cnt + CW'(1);
                    if (cnt == CNT_LAST) state <= ST_DONE;
                end
                ST_DIV: begin
                    rem <= div_ok ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
                    opa <= quot_nx;
                    cnt <= cnt + CW'(1);
                    if (cnt == CNT_LAST) state <= ST_DONE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/execute_muldiv.md
Name: execute_muldiv

Overview:
Execute stage for the nonpipelined LEGv8 core. It sits directly upstream of the Memory stage and produces the 64-bit ALU result, which Memory uses as its data address, and the zero flag, which Memory uses for CBZ/B.cond branch resolution. Single-cycle ALU ops share a small FSM with an iterative shift-add multiplier and a restoring divider (MUL, UDIV, SDIV). The control unit stalls on a valid/ready handshake until the result is posted.

Parameters:
WIDTH, 64, datapath width in bits (matches `WORD).

Ports:
clk  in  1  stage clock, rising edge
reset  in  1  synchronous, active-high
in_valid  in  1  operands and op valid this cycle
in_ready  out  1  stage can accept an op (high only in IDLE)
alu_control  in  4  0000 AND, 0001 ORR, 0010 ADD, 0110 SUB, 0111 PASSB, 1100 NOR, 1000 MUL, 1001 UDIV, 1010 SDIV
a  in  WIDTH  operand A (Rn)
b  in  WIDTH  operand B (Rm or immediate, ALUSrc mux is upstream)
out_valid  out  1  one-cycle pulse: result/zero updated
result  out  WIDTH  registered result, drives Memory address
zero  out  1  registered (result == 0)
nzcv  out  4  present only with EXEC_FLAGS_EN

Behaviour:
- One clock, clk; reset is synchronous and active-high.
- Reset: state=IDLE, in_ready=1, out_valid=0, result=0, zero=1, nzcv=0 (if present). Reset during MUL/DIV aborts the operation. No out_valid is produced for the aborted op.
- Accept: at a rising edge where in_valid && in_ready. a, b and alu_control are latched, and later input changes are ignored. in_valid while busy is ignored.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE -> DONE for single-cycle ops, for undefined codes, and for divide-by-zero.
  - IDLE -> MUL for code 1000.
  - IDLE -> DIV for 1001/1010 with b != 0.
  - MUL -> DONE after WIDTH iterations. DIV -> DONE after WIDTH iterations.
  - DONE -> IDLE unconditionally.
- out_valid=1 only in DONE. result and zero are written on the edge entering DONE and hold until the next op's DONE.
- Latency from the accept edge N:
  - Single-cycle ops: out_valid sampled high at edge N+1.
  - MUL/DIV: out_valid sampled high at edge N+WIDTH+1.
  - Divide-by-zero: out_valid sampled high at edge N+1.
  - Next accept is possible at edge N+2 (single-cycle) or N+WIDTH+2 (MUL/DIV).
- Arithmetic, all modulo 2^WIDTH:
  - ADD = a+b; SUB = a-b; PASSB = b; NOR = ~(a|b).
  - Undefined codes give result=0.
- MUL: shift-add, one multiplier bit per cycle, LSB first. Result is the low WIDTH bits of the product, identical for signed and unsigned.
- UDIV: restoring division, one quotient bit per cycle MSB first, truncating quotient.
- SDIV: divides magnitudes unsigned, then negates the quotient if sign(a) != sign(b). This truncates toward zero. Most-negative / -1 returns most-negative (wrap, no trap).
- Divide by zero (UDIV/SDIV with b==0): result=0, zero=1. ARMv8 semantics.
- zero is recomputed for every op, including MUL/DIV/undefined.

Optional Feature:
EXEC_FLAGS_EN.
- Defined: the nzcv port exists and is registered alongside result.
  - N = result[WIDTH-1]; Z = zero.
  - C = carry-out for ADD, NOT-borrow (a >= b unsigned) for SUB.
  - V = signed overflow for ADD/SUB.
  - C and V are 0 for all other ops.
- Undefined: the nzcv port and its logic are absent. All other behaviour is identical.

Test Plan:
- Reset mid-MUL: assert reset 10 cycles after accepting MUL 3*5 -> no out_valid. Next cycle in_ready=1, result=0, zero=1.
- ADD a=7, b=9 -> out_valid at edge N+1, result=16, zero=0. SUB a=5, b=5 -> result=0, zero=1. in_ready low for exactly one cycle.
- MUL a=0xFFFF_FFFF_FFFF_FFFF (-1), b=6 -> out_valid at N+65, result=0xFFFF_FFFF_FFFF_FFFA. in_ready=0 through cycles N+1..N+65. A new in_valid held during busy is not accepted until edge N+66.
- Division:
  - UDIV 100/7 -> 14.
  - SDIV -100/7 -> 0xFFFF_FFFF_FFFF_FFF2 (-14).
  - SDIV 0x8000_0000_0000_0000 / -1 -> 0x8000_0000_0000_0000.
  - UDIV 42/0 -> result=0, zero=1, out_valid at N+1.
- Operand stability: change a/b/alu_control on the cycle after accepting UDIV 64/8 -> result=8 at N+65.
- With EXEC_FLAGS_EN: ADD 0x7FFF_FFFF_FFFF_FFFF+1 -> nzcv=1001. SUB 3-5 -> nzcv=1000. SUB 5-3 -> nzcv=0010.
